// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush scheduler.
// The pipeline side (master) raises requests; the scheduler (slave) answers
// with per-stage hold, bubble/flush strobes and multi-cycle status.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              id_ld_use_req;
  logic              br_flush_req;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              ex_mc_abort;
  logic              perf_clr;
  logic [5:0]        stall_out;
  logic              bubble_id_ex;
  logic              flush_if_id;
  logic              ex_mc_done;
  logic              busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_ld_use_req, br_flush_req, ex_mc_start, ex_mc_cycles,
           ex_mc_abort, perf_clr,
    input  stall_out, bubble_id_ex, flush_if_id, ex_mc_done, busy,
           stall_cycles
  );

  modport slave (
    input  id_ld_use_req, br_flush_req, ex_mc_start, ex_mc_cycles,
           ex_mc_abort, perf_clr,
    output stall_out, bubble_id_ex, flush_if_id, ex_mc_done, busy,
           stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline. Merges load-use
// hazards, multi-cycle ex operations and taken-branch flushes into a single
// per-stage hold vector, and counts stalled cycles for performance monitoring.
// Note: rst_n is a synchronous, active-HIGH reset (asserted = 1).
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_stall_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_MC_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_W'(2);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              done_r;
  logic [PERF_W-1:0] stall_cycles_r;
  logic              ex_stall_s;
  logic [5:0]        stall_s;
  logic              bubble_s;
  logic              flush_s;

  // Multi-cycle sequencer: next state and down-counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ex_mc_start) begin
          if (bus.ex_mc_cycles > CNT_TWO) begin
            // cnt covers the BUSY cycles after the start cycle
            cnt_nxt_s   = bus.ex_mc_cycles - CNT_TWO;
            state_nxt_s = ST_MC_BUSY;
          end else begin
            state_nxt_s = ST_MC_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MC_BUSY: begin
        if (bus.ex_mc_abort) begin
          // abort wins over expiry; the op is dropped without a done pulse
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_MC_DONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_MC_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Ex hold: the start cycle of a long op, plus every BUSY cycle.
  always_comb begin
    if ((state_r == ST_IDLE) && bus.ex_mc_start && (bus.ex_mc_cycles >= CNT_TWO)) begin
      ex_stall_s = 1'b1;
    end else if (state_r == ST_MC_BUSY) begin
      ex_stall_s = 1'b1;
    end else begin
      ex_stall_s = 1'b0;
    end
  end

  // Priority merge of stall sources; id requests are suppressed while ex holds
  // because id will re-present them once the pipeline moves again.
  always_comb begin
    stall_s  = 6'b000000;
    bubble_s = 1'b0;
    flush_s  = 1'b0;
    if (rst_n) begin
      stall_s  = 6'b000000;
    end else if (ex_stall_s) begin
      stall_s  = 6'b001111;
    end else if (bus.id_ld_use_req) begin
      // branch is not resolved while its operand is pending, so no flush
      stall_s  = 6'b000011;
      bubble_s = 1'b1;
    end else if (bus.br_flush_req) begin
      flush_s  = 1'b1;
    end else begin
      stall_s  = 6'b000000;
    end
  end

  // Sequencer state, counter and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= (state_nxt_s == ST_MC_DONE);
    end
  end

  // Saturating stalled-cycle counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (bus.perf_clr) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (stall_s[0] && (stall_cycles_r != PERF_MAX)) begin
      stall_cycles_r <= stall_cycles_r + PERF_ONE;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.stall_out    = stall_s;
  assign bus.bubble_id_ex = bubble_s;
  assign bus.flush_if_id  = flush_s;
  assign bus.ex_mc_done   = done_r;
  assign bus.busy         = (~rst_n) & (state_r != ST_IDLE);
  assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-position reference model.
module tb_pipe_stall_ctrl;

  localparam int CNT_W    = 6;
  localparam int PERF_W   = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an op is tracked by its length n and cycle offset k
  // since the start cycle (k=1 is the cycle after start).
  bit m_in_op = 1'b0;
  int m_k     = 0;
  int m_n     = 0;
  int m_cnt   = 0;

  function automatic int done_k(input int n);
    return (n >= 2) ? n - 1 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input bit br, input bit st,
                     input int n, input bit ab, input bit clr);
    logic [5:0] e_stall;
    bit e_bub, e_fl, e_busy, e_done, ex_st;
    @(negedge clk);
    rst_n             = r;
    bus.id_ld_use_req = ld;
    bus.br_flush_req  = br;
    bus.ex_mc_start   = st;
    bus.ex_mc_cycles  = CNT_W'(n);
    bus.ex_mc_abort   = ab;
    bus.perf_clr      = clr;
    #1;
    ex_st   = (!m_in_op && st && n >= 2) || (m_in_op && m_k <= m_n - 2);
    e_stall = 6'b000000;
    e_bub   = 1'b0;
    e_fl    = 1'b0;
    e_busy  = 1'b0;
    if (!r) begin
      e_busy = m_in_op;
      if (ex_st) e_stall = 6'b001111;
      else if (ld) begin e_stall = 6'b000011; e_bub = 1'b1; end
      else if (br) e_fl = 1'b1;
    end
    e_done = m_in_op && (m_k == done_k(m_n));
    check("stall_out",    32'(bus.stall_out),    32'(e_stall));
    check("bubble_id_ex", 32'(bus.bubble_id_ex), 32'(e_bub));
    check("flush_if_id",  32'(bus.flush_if_id),  32'(e_fl));
    check("busy",         32'(bus.busy),         32'(e_busy));
    check("ex_mc_done",   32'(bus.ex_mc_done),   32'(e_done));
    check("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
    @(posedge clk);
    if (r || clr) m_cnt = 0;
    else if (e_stall[0] && m_cnt < PERF_MAX) m_cnt++;
    if (r) m_in_op = 1'b0;
    else if (!m_in_op) begin
      if (st) begin m_in_op = 1'b1; m_k = 1; m_n = n; end
    end
    else if (ab && m_k <= m_n - 2) m_in_op = 1'b0;
    else if (m_k == done_k(m_n)) m_in_op = 1'b0;
    else m_k++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with every request asserted
    rst_n = 1'b1;
    bus.id_ld_use_req = 1'b1; bus.br_flush_req = 1'b1; bus.ex_mc_start = 1'b1;
    bus.ex_mc_cycles = CNT_W'(5); bus.ex_mc_abort = 1'b1; bus.perf_clr = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b1);

    // Load-use for one cycle
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1 check("ld_use_cnt", 32'(bus.stall_cycles), 32'd1);
    idle(1);

    // Multi-cycle N=5, then N=2, then N=1
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    idle(4);
    #1 check("mc5_cnt", 32'(bus.stall_cycles), 32'd5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    idle(2);
    #1 check("mc2_cnt", 32'(bus.stall_cycles), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    idle(2);

    // Overlap: long op starting while id requests are asserted
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);

    // Abort at t+3 with a stray start during BUSY
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    #1 check("abort_busy", 32'(bus.busy), 32'd0);
    idle(12);

    // Saturation with a 20-cycle stall
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 21, 1'b0, 1'b0);
    idle(21);
    #1 check("sat_cnt", 32'(bus.stall_cycles), 32'd15);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    #1 check("clr_prio", 32'(bus.stall_cycles), 32'd0);

    // Reset in the middle of BUSY
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1 check("rst_mid_busy", 32'(bus.busy), 32'd0);
    idle(10);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 12)),
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
